score_display: RTL and testbench

//  Consumer end of the 16-bit score bus produced by getscore. Converts binary score
//  to 4 BCD digits with a sequential shift-add-3 engine, then time-multiplexes them

---
 rtl/score_disp_pkg.sv | 25 ++
 rtl/bin2bcd_seq.sv | 72 +++++++
 rtl/score_display.sv | 91 +++++++++
 tb/tb_score_display.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/score_disp_pkg.sv
// Shared types and constants for the score display path: converter FSM states,
// 7-segment code table and the blank/saturation constants.
package score_disp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } b2b_state_e;

    // seg[6:0] = {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] SEG_CODE [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    localparam logic [7:0]  SEG_OFF   = 8'hFF;
    localparam logic [3:0]  AN_OFF    = 4'hF;
    localparam logic [15:0] SCORE_MAX = 16'd9999;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        seg_of = (d <= 4'd9) ? SEG_CODE[d] : 7'h7F;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 converter: 14-bit binary to 4 BCD digits in 14 shift
// cycles plus one DONE cycle; bcd_o is valid while done_o is high.
module bin2bcd_seq
    import score_disp_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [13:0] src_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] bcd_o
);

    b2b_state_e  state_q, state_d;
    logic [29:0] sh_q, sh_d;    // {bcd[15:0], src[13:0]}
    logic [3:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic [29:0] adj;

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        adj     = sh_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    sh_d    = {16'h0000, src_i};
                    cnt_d   = 4'd0;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                for (int i = 0; i < 4; i++) begin
                    if (adj[14 + 4*i +: 4] >= 4'd5)
                        adj[14 + 4*i +: 4] = adj[14 + 4*i +: 4] + 4'd3;
                end
                sh_d  = {adj[28:0], 1'b0};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd13)
                    state_d = DONE;
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = (state_q == DONE);
    assign bcd_o  = sh_q[29:14];

endmodule

// File: rtl/score_display.sv
// Score bus consumer: saturates and converts the score to BCD, then scans four
// common-anode digits. Define SCORE_LEADING_ZERO_BLANK_EN to blank leading zeros.
module score_display
    import score_disp_pkg::*;
#(
    parameter logic [15:0] SCAN_DIV = 16'd50000
) (
    input  logic        work_clk,
    input  logic        rst,
    input  logic [1:0]  scene,
    input  logic [15:0] score,
    output logic [7:0]  seg,
    output logic [3:0]  an,
    output logic        busy
);

    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic [13:0] src_q, src_d;
    logic [15:0] dig_q, dig_d;
    logic [7:0]  seg_q, seg_d;
    logic [3:0]  an_q, an_d;

    logic [13:0] sat;
    logic        start, cvt_busy, cvt_done, show;
    logic [15:0] cvt_bcd;
    logic [3:0]  cur;
`ifdef SCORE_LEADING_ZERO_BLANK_EN
    logic [1:0]  msd;
`endif

    assign sat   = (score > SCORE_MAX) ? SCORE_MAX[13:0] : score[13:0];
    assign start = (scene == 2'd1) && !cvt_busy && (sat != src_q);

    bin2bcd_seq u_cvt (
        .clk_i   (work_clk),
        .rst_i   (rst),
        .start_i (start),
        .src_i   (sat),
        .busy_o  (cvt_busy),
        .done_o  (cvt_done),
        .bcd_o   (cvt_bcd)
    );

    always_comb begin
        cnt_d = (cnt_q == SCAN_DIV - 16'd1) ? 16'd0 : cnt_q + 16'd1;
        idx_d = (cnt_q == SCAN_DIV - 16'd1) ? idx_q + 2'd1 : idx_q;
        src_d = start ? sat : src_q;
        dig_d = cvt_done ? cvt_bcd : dig_q;
        cur   = dig_q[{idx_q, 2'b00} +: 4];
        show  = 1'b1;
`ifdef SCORE_LEADING_ZERO_BLANK_EN
        msd = 2'd0;
        if (dig_q[15:12] != 4'd0)     msd = 2'd3;
        else if (dig_q[11:8] != 4'd0) msd = 2'd2;
        else if (dig_q[7:4] != 4'd0)  msd = 2'd1;
        show = (idx_q <= msd);
`endif
        // scene 1 and 2 drive the display; 0 and 3 blank it
        if ((scene == 2'd1 || scene == 2'd2) && show) begin
            seg_d = {1'b1, seg_of(cur)};
            an_d  = ~(4'b0001 << idx_q);
        end else begin
            seg_d = SEG_OFF;
            an_d  = AN_OFF;
        end
    end

    always_ff @(posedge work_clk) begin
        if (rst) begin
            cnt_q <= '0;
            idx_q <= '0;
            src_q <= '0;
            dig_q <= '0;
            seg_q <= SEG_OFF;
            an_q  <= AN_OFF;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            src_q <= src_d;
            dig_q <= dig_d;
            seg_q <= seg_d;
            an_q  <= an_d;
        end
    end

    assign seg  = seg_q;
    assign an   = an_q;
    assign busy = cvt_busy;

endmodule

// File: tb/tb_score_display.sv
// Directed bench for score_display with SCAN_DIV=4; outputs sampled on negedge.
module tb_score_display;

    logic        work_clk = 1'b0;
    logic        rst;
    logic [1:0]  scene;
    logic [15:0] score;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic        busy;

    int tests = 0;
    int fails = 0;

    score_display #(.SCAN_DIV(16'd4)) dut (
        .work_clk (work_clk),
        .rst      (rst),
        .scene    (scene),
        .score    (score),
        .seg      (seg),
        .an       (an),
        .busy     (busy)
    );

    always #5 work_clk = ~work_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // counts consecutive busy samples, bounded
    task automatic busy_run(output int n);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge work_clk);
            if (busy) n++;
            else break;
        end
    endtask

    // records seg seen in each digit slot; 0 means the slot never appeared
    task automatic capture(input int n, output logic [7:0] s0, output logic [7:0] s1,
                           output logic [7:0] s2, output logic [7:0] s3,
                           output int blank, output int bad);
        s0 = 8'h00; s1 = 8'h00; s2 = 8'h00; s3 = 8'h00; blank = 0; bad = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge work_clk);
            case (an)
                4'hE: s0 = seg;
                4'hD: s1 = seg;
                4'hB: s2 = seg;
                4'h7: s3 = seg;
                4'hF: blank++;
                default: bad++;
            endcase
        end
    endtask

    int n, blank, bad, cnt;
    logic [7:0] s0, s1, s2, s3;

    initial begin
        rst = 1'b1; scene = 2'd1; score = 16'd1234;
        repeat (3) @(negedge work_clk);
        chk("rst_seg", seg, 8'hFF);
        chk("rst_an", an, 4'hF);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b0; scene = 2'd0;
        capture(10, s0, s1, s2, s3, blank, bad);
        chk("menu_blank", blank, 10);
        chk("menu_busy", busy, 1'b0);

        // 1234
        scene = 2'd1; score = 16'd1234;
        busy_run(n);
        chk("busy_len_1234", n, 15);
        capture(16, s0, s1, s2, s3, blank, bad);
        chk("d0_1234", s0, 8'h99);
        chk("d1_1234", s1, 8'hB0);
        chk("d2_1234", s2, 8'hA4);
        chk("d3_1234", s3, 8'hF9);
        chk("an_1234", blank + bad, 0);

        // saturation of 12345
        score = 16'd12345;
        busy_run(n);
        chk("busy_len_sat", n, 15);
        capture(16, s0, s1, s2, s3, blank, bad);
        chk("d0_sat", s0, 8'h90);
        chk("d1_sat", s1, 8'h90);
        chk("d2_sat", s2, 8'h90);
        chk("d3_sat", s3, 8'h90);

        // game over freezes display
        score = 16'd50;
        busy_run(n);
        chk("busy_len_50", n, 15);
        scene = 2'd2; score = 16'd60;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge work_clk);
            if (busy) cnt++;
        end
        chk("over_no_busy", cnt, 0);
        capture(16, s0, s1, s2, s3, blank, bad);
        chk("d0_over", s0, 8'hC0);
        chk("d1_over", s1, 8'h92);
        chk("d2_over", s2, 8'hC0);
        chk("d3_over", s3, 8'hC0);

        // change during SHIFT: last value wins
        scene = 2'd1; score = 16'd100;
        repeat (5) @(negedge work_clk);
        score = 16'd101;
        busy_run(n);
        chk("busy_rest_100", n, 10);
        @(negedge work_clk);
        chk("second_cvt", busy, 1'b1);
        capture(14, s0, s1, s2, s3, blank, bad);
        chk("d0_100", s0, 8'hC0);
        chk("d1_100", s1, 8'hC0);
        chk("d2_100", s2, 8'hF9);
        chk("d3_100", s3, 8'hC0);
        busy_run(n);
        capture(16, s0, s1, s2, s3, blank, bad);
        chk("d0_101", s0, 8'hF9);
        chk("d1_101", s1, 8'hC0);
        chk("d2_101", s2, 8'hF9);
        chk("d3_101", s3, 8'hC0);

        // reserved scene blanks like menu
        scene = 2'd3;
        repeat (2) @(negedge work_clk);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge work_clk);
            if (an != 4'hF || seg != 8'hFF || busy) cnt++;
        end
        chk("scene3_blank", cnt, 0);

        // full-scale input saturates
        scene = 2'd1; score = 16'hFFFF;
        busy_run(n);
        chk("busy_len_ffff", n, 15);
        capture(16, s0, s1, s2, s3, blank, bad);
        chk("d0_ffff", s0, 8'h90);
        chk("d3_ffff", s3, 8'h90);

        score = 16'd7;
        busy_run(n);
        capture(16, s0, s1, s2, s3, blank, bad);
`ifdef SCORE_LEADING_ZERO_BLANK_EN
        chk("lz7_d0", s0, 8'hF8);
        chk("lz7_hidden", {s1, s2, s3}, 24'h000000);
        chk("lz7_bad", bad, 0);
        score = 16'd0;
        busy_run(n);
        capture(16, s0, s1, s2, s3, blank, bad);
        chk("lz0_d0", s0, 8'hC0);
        chk("lz0_hidden", {s1, s2, s3}, 24'h000000);
`else
        chk("d0_7", s0, 8'hF8);
        chk("d1_7", s1, 8'hC0);
        chk("d2_7", s2, 8'hC0);
        chk("d3_7", s3, 8'hC0);
        score = 16'd0;
        busy_run(n);
        chk("busy_len_0", n, 15);
        capture(16, s0, s1, s2, s3, blank, bad);
        chk("d0_0", s0, 8'hC0);
        chk("d3_0", s3, 8'hC0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
